// File: rtl/circuit_sequencer_if.sv
// ---------------------------------------------------------------------------
// circuit_sequencer_if
// Bundles every non-clock/reset signal of the circuit sequencer.
//
// Vector layout   : [2*D-1:0][N-1:0], element k real part at index 2k,
//                   imaginary part at index 2k+1 (Q15 sign-magnitude).
// Matrix layout   : [2*D*D-1:0][N-1:0], entry (row r, col c) real part at
//                   index 2*(r*D+c), imaginary part at index 2*(r*D+c)+1.
//
// Signals:
//   start        host -> seq   one-cycle run request (honoured in IDLE only)
//   num_gates    host -> seq   gate count K, sampled with start
//   init_vector  host -> seq   initial state vector, sampled with start
//   gate_addr    seq  -> mem   gate-memory read address
//   gate_matrix  mem  -> seq   read data, valid one cycle after gate_addr
//   mm_matrix    seq  -> mm    matrix operand of the matmul
//   mm_i_vector  seq  -> mm    vector operand of the matmul
//   mm_o_vector  mm   -> seq   combinational matmul result
//   mm_ovr       mm   -> seq   OR of the matmul overflow flags
//   busy         seq  -> host  high in every state except IDLE
//   done         seq  -> host  one-cycle completion pulse
//   o_vector     seq  -> host  final state vector
//   ovr_flag     seq  -> host  sticky overflow of the current/last run
//
// master = environment (host, gate memory, matmul); slave = sequencer.
// ---------------------------------------------------------------------------
interface circuit_sequencer_if #(
    parameter int N         = 16,
    parameter int D         = 4,
    parameter int MAX_GATES = 8
);
    localparam int GW = $clog2(MAX_GATES);
    localparam int CW = $clog2(MAX_GATES + 1);

    logic                        start;
    logic [CW-1:0]               num_gates;
    logic [2*D-1:0][N-1:0]       init_vector;
    logic [GW-1:0]               gate_addr;
    logic [2*D*D-1:0][N-1:0]     gate_matrix;
    logic [2*D*D-1:0][N-1:0]     mm_matrix;
    logic [2*D-1:0][N-1:0]       mm_i_vector;
    logic [2*D-1:0][N-1:0]       mm_o_vector;
    logic                        mm_ovr;
    logic                        busy;
    logic                        done;
    logic [2*D-1:0][N-1:0]       o_vector;
    logic                        ovr_flag;

    modport master (
        output start, num_gates, init_vector, gate_matrix, mm_o_vector, mm_ovr,
        input  gate_addr, mm_matrix, mm_i_vector, busy, done, o_vector, ovr_flag
    );

    modport slave (
        input  start, num_gates, init_vector, gate_matrix, mm_o_vector, mm_ovr,
        output gate_addr, mm_matrix, mm_i_vector, busy, done, o_vector, ovr_flag
    );
endinterface

// File: rtl/circuit_sequencer.sv
// ---------------------------------------------------------------------------
// circuit_sequencer
// Applies a list of K two-qubit gates (read from an external gate memory)
// to a state vector, one gate at a time, through an external combinational
// matmul. Gate 0 is applied first, so the result is G[K-1]*...*G[0]*init.
// Each gate costs three cycles (FETCH, CAPTURE, APPLY); a run with start at
// cycle 0 pulses done at cycle 3*Keff+1, Keff = min(num_gates, MAX_GATES).
//
// Ports:
//   clk  - clock, all state updates on the rising edge
//   rst  - synchronous active-high reset, priority over everything
//   bus  - circuit_sequencer_if.slave (handshake, gate memory, matmul,
//          result and status signals)
// ---------------------------------------------------------------------------
module circuit_sequencer #(
    parameter int N         = 16,
    parameter int D         = 4,
    parameter int MAX_GATES = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    circuit_sequencer_if.slave    bus
);
    localparam int GW = $clog2(MAX_GATES);
    localparam int CW = $clog2(MAX_GATES + 1);
    localparam int VW = 2 * D;
    localparam int MW = 2 * D * D;
    localparam logic [CW-1:0] MAXG_C = CW'(MAX_GATES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_CAPTURE,
        S_APPLY,
        S_DONE
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [GW-1:0]         r_g;
    logic [GW-1:0]         r_gate_addr;
    logic [CW-1:0]         r_keff;
    logic [VW-1:0][N-1:0]  r_vec;
    logic [MW-1:0][N-1:0]  r_mat;
    logic                  r_ovr;

    logic [CW-1:0]         w_keff;
    logic [CW-1:0]         w_g_inc;
    logic                  w_last;
    logic                  w_busy;
    logic                  w_done;

    // Clamp the requested gate count to the memory depth.
    assign w_keff  = (bus.num_gates > MAXG_C) ? MAXG_C : bus.num_gates;

    // g == Keff-1 expressed as g+1 == Keff so only the increment is needed.
    assign w_g_inc = CW'(r_g) + CW'(1);
    assign w_last  = (w_g_inc == r_keff);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        w_busy = 1'b1;
        w_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                if (bus.start) begin
                    w_next = (w_keff != '0) ? S_FETCH : S_DONE;
                end
            end
            S_FETCH:   w_next = S_CAPTURE;
            S_CAPTURE: w_next = S_APPLY;
            S_APPLY:   w_next = w_last ? S_DONE : S_FETCH;
            S_DONE: begin
                w_done = 1'b1;
                w_next = S_IDLE;
            end
            default:   w_next = S_IDLE;
        endcase
    end

    // gate_addr is loaded on every transition into FETCH, so it equals g
    // during FETCH and keeps that value until the next fetch.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_g         <= '0;
            r_gate_addr <= '0;
            r_keff      <= '0;
            r_vec       <= '0;
            r_mat       <= '0;
            r_ovr       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_vec  <= bus.init_vector;
                        r_g    <= '0;
                        r_ovr  <= 1'b0;
                        r_keff <= w_keff;
                        if (w_keff != '0) begin
                            r_gate_addr <= '0;
                        end
                    end
                end
                S_CAPTURE: begin
                    r_mat <= bus.gate_matrix;
                end
                S_APPLY: begin
                    r_vec <= bus.mm_o_vector;
                    r_ovr <= r_ovr | bus.mm_ovr;
                    if (!w_last) begin
                        r_g         <= r_g + GW'(1);
                        r_gate_addr <= r_g + GW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.gate_addr   = r_gate_addr;
    assign bus.mm_matrix   = r_mat;
    assign bus.mm_i_vector = r_vec;
    assign bus.o_vector    = r_vec;
    assign bus.busy        = w_busy;
    assign bus.done        = w_done;
    assign bus.ovr_flag    = r_ovr;

endmodule

// File: tb/tb_circuit_sequencer.sv
module tb_circuit_sequencer;
    localparam int N  = 16;
    localparam int D  = 4;
    localparam int MG = 8;

    typedef logic [2*D-1:0][N-1:0]   vec_t;
    typedef logic [2*D*D-1:0][N-1:0] mat_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    circuit_sequencer_if #(.N(N), .D(D), .MAX_GATES(MG)) bus();

    circuit_sequencer #(.N(N), .D(D), .MAX_GATES(MG)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Gate memory: registered read, data valid one cycle after the address.
    mat_t mem [MG];
    always @(posedge clk) bus.gate_matrix <= mem[bus.gate_addr];

    // Reference complex matmul on Q15 sign-magnitude words.
    function automatic int sm2i(input logic [15:0] x);
        int mag;
        mag = int'({17'd0, x[14:0]});
        return x[15] ? -mag : mag;
    endfunction

    function automatic logic [15:0] i2sm(input int a);
        int m;
        m = (a < 0) ? -a : a;
        return {(a < 0), m[14:0]};
    endfunction

    function automatic vec_t mm(input mat_t m, input vec_t v);
        vec_t res;
        int   are, aim, mre, mim, vre, vim;
        res = '0;
        for (int r = 0; r < D; r++) begin
            are = 0;
            aim = 0;
            for (int c = 0; c < D; c++) begin
                mre = sm2i(m[2*(r*D+c)]);
                mim = sm2i(m[2*(r*D+c)+1]);
                vre = sm2i(v[2*c]);
                vim = sm2i(v[2*c+1]);
                are = are + ((mre * vre) >>> 15) - ((mim * vim) >>> 15);
                aim = aim + ((mre * vim) >>> 15) + ((mim * vre) >>> 15);
            end
            res[2*r]   = i2sm(are);
            res[2*r+1] = i2sm(aim);
        end
        return res;
    endfunction

    always_comb bus.mm_o_vector = mm(bus.mm_matrix, bus.mm_i_vector);

    function automatic mat_t half_i();
        mat_t m;
        m = '0;
        for (int i = 0; i < D; i++) m[2*(i*D+i)] = 16'h4000;
        return m;
    endfunction

    function automatic vec_t e0_half();
        vec_t v;
        v = '0;
        v[0] = 16'h4000;
        return v;
    endfunction

    // Per-cycle history captured by run(), indexed by cycle after start.
    logic       dh [0:63];
    logic       bh [0:63];
    logic [2:0] ah [0:63];
    logic       oh [0:63];
    vec_t       ovs;
    logic       ovrs;

    task automatic kick(input logic [3:0] k, input vec_t iv);
        @(negedge clk);
        bus.start       = 1'b1;
        bus.num_gates   = k;
        bus.init_vector = iv;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // Runs for a fixed number of cycles after a kick, recording outputs.
    // spc/ovc select the cycle in which start / mm_ovr are pulsed (-1: none).
    task automatic run(input int budget, input int spc, input int ovc,
                       output int dcyc, output int ndone);
        dcyc  = -1;
        ndone = 0;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            dh[c] = bus.done;
            bh[c] = bus.busy;
            ah[c] = bus.gate_addr;
            oh[c] = bus.ovr_flag;
            if (bus.done === 1'b1) begin
                ndone++;
                if (dcyc < 0) begin
                    dcyc = c;
                    ovs  = bus.o_vector;
                    ovrs = bus.ovr_flag;
                end
            end
            bus.start  = (c == spc);
            bus.mm_ovr = (c == ovc);
        end
        bus.start  = 1'b0;
        bus.mm_ovr = 1'b0;
    endtask

    task automatic test_reset();
        rst             = 1'b1;
        bus.start       = 1'b0;
        bus.mm_ovr      = 1'b0;
        bus.num_gates   = '0;
        bus.init_vector = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", bus.done); end
        total++; if (bus.ovr_flag !== 1'b0) begin bad++; $display("FAIL reset_ovr got=%b exp=0", bus.ovr_flag); end
        total++; if (bus.gate_addr !== 3'd0) begin bad++; $display("FAIL reset_addr got=%0d exp=0", bus.gate_addr); end
        total++; if (bus.o_vector !== vec_t'(0)) begin bad++; $display("FAIL reset_ovec got=%h exp=0", bus.o_vector); end
        total++; if (bus.mm_matrix !== mat_t'(0)) begin bad++; $display("FAIL reset_mmat got=%h exp=0", bus.mm_matrix); end
        // rst and start together: reset wins
        bus.start     = 1'b1;
        bus.num_gates = 4'd1;
        @(negedge clk);
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_prio_busy got=%b exp=0", bus.busy); end
        rst       = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL idle_busy got=%b exp=0", bus.busy); end
    endtask

    task automatic test_single();
        int d, n;
        vec_t exp_v;
        mem[0] = half_i();
        kick(4'd1, e0_half());
        run(8, -1, -1, d, n);
        exp_v = '0; exp_v[0] = 16'h2000;
        total++; if (d !== 4) begin bad++; $display("FAIL single_done_cyc got=%0d exp=4", d); end
        total++; if (n !== 1) begin bad++; $display("FAIL single_done_cnt got=%0d exp=1", n); end
        total++; if (ovs !== exp_v) begin bad++; $display("FAIL single_vec got=%h exp=%h", ovs, exp_v); end
        total++; if (ovrs !== 1'b0) begin bad++; $display("FAIL single_ovr got=%b exp=0", ovrs); end
    endtask

    task automatic test_two();
        int d, n;
        vec_t exp_v;
        mem[0] = half_i();
        mem[1] = half_i();
        kick(4'd2, e0_half());
        run(10, -1, -1, d, n);
        exp_v = '0; exp_v[0] = 16'h1000;
        total++; if (d !== 7) begin bad++; $display("FAIL two_done_cyc got=%0d exp=7", d); end
        total++; if (ovs !== exp_v) begin bad++; $display("FAIL two_vec got=%h exp=%h", ovs, exp_v); end
        total++; if (ah[1] !== 3'd0) begin bad++; $display("FAIL two_addr_fetch0 got=%0d exp=0", ah[1]); end
        total++; if (ah[4] !== 3'd1) begin bad++; $display("FAIL two_addr_fetch1 got=%0d exp=1", ah[4]); end
    endtask

    task automatic test_order();
        int d, n;
        vec_t exp_v;
        mat_t g0, g1;
        g0 = '0; g0[8] = 16'h4000;                     // row1,col0 = 0.5
        g1 = '0; g1[0] = 16'h2000; g1[10] = 16'h4000;  // diag(0.25, 0.5, 0, 0)
        mem[0] = g0;
        mem[1] = g1;
        kick(4'd2, e0_half());
        run(10, -1, -1, d, n);
        exp_v = '0; exp_v[2] = 16'h1000;
        total++; if (ovs !== exp_v) begin bad++; $display("FAIL order_vec got=%h exp=%h", ovs, exp_v); end
    endtask

    task automatic test_zero();
        int d, n;
        vec_t iv;
        for (int i = 0; i < 2*D; i++) iv[i] = 16'(16'h8A0F + i * 16'h1357);
        kick(4'd0, iv);
        run(5, -1, -1, d, n);
        total++; if (d !== 1) begin bad++; $display("FAIL zero_done_cyc got=%0d exp=1", d); end
        total++; if (ovs !== iv) begin bad++; $display("FAIL zero_vec got=%h exp=%h", ovs, iv); end
        total++; if (n !== 1) begin bad++; $display("FAIL zero_done_cnt got=%0d exp=1", n); end
    endtask

    task automatic test_busy_start();
        int d, n, nb;
        vec_t exp_v;
        for (int i = 0; i < 3; i++) mem[i] = half_i();
        kick(4'd3, e0_half());
        run(14, 3, -1, d, n);
        nb = 0;
        for (int c = 1; c <= 9; c++) if (bh[c] === 1'b1) nb++;
        exp_v = '0; exp_v[0] = 16'h0800;
        total++; if (d !== 10) begin bad++; $display("FAIL bstart_done_cyc got=%0d exp=10", d); end
        total++; if (n !== 1) begin bad++; $display("FAIL bstart_done_cnt got=%0d exp=1", n); end
        total++; if (nb !== 9) begin bad++; $display("FAIL bstart_busy_cycles got=%0d exp=9", nb); end
        total++; if (bh[11] !== 1'b0) begin bad++; $display("FAIL bstart_busy_after got=%b exp=0", bh[11]); end
        total++; if (ovs !== exp_v) begin bad++; $display("FAIL bstart_vec got=%h exp=%h", ovs, exp_v); end
    endtask

    task automatic test_overflow();
        int d, n;
        for (int i = 0; i < 3; i++) mem[i] = half_i();
        kick(4'd3, e0_half());
        run(12, -1, 6, d, n);
        total++; if (oh[5] !== 1'b0) begin bad++; $display("FAIL ovr_before got=%b exp=0", oh[5]); end
        total++; if (ovrs !== 1'b1) begin bad++; $display("FAIL ovr_at_done got=%b exp=1", ovrs); end
        total++; if (bus.ovr_flag !== 1'b1) begin bad++; $display("FAIL ovr_sticky_idle got=%b exp=1", bus.ovr_flag); end
        kick(4'd1, e0_half());
        run(6, -1, -1, d, n);
        total++; if (oh[1] !== 1'b0) begin bad++; $display("FAIL ovr_clear_start got=%b exp=0", oh[1]); end
        total++; if (d !== 4) begin bad++; $display("FAIL ovr_rerun_done got=%0d exp=4", d); end
    endtask

    task automatic test_max_gates();
        int d, n;
        vec_t exp_v;
        for (int i = 0; i < MG; i++) mem[i] = half_i();
        kick(4'd11, e0_half());
        run(30, -1, -1, d, n);
        exp_v = '0; exp_v[0] = 16'h0040;
        total++; if (d !== 25) begin bad++; $display("FAIL maxg_done_cyc got=%0d exp=25", d); end
        total++; if (ovs !== exp_v) begin bad++; $display("FAIL maxg_vec got=%h exp=%h", ovs, exp_v); end
        total++; if (ah[22] !== 3'd7) begin bad++; $display("FAIL maxg_last_addr got=%0d exp=7", ah[22]); end
    endtask

    task automatic test_reset_mid();
        int d, n, nd;
        vec_t exp_v;
        mem[0] = half_i();
        mem[1] = half_i();
        kick(4'd2, e0_half());
        nd = 0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (bus.done === 1'b1) nd++;
        end
        rst = 1'b1;                 // asserted in CAPTURE of gate 1 (cycle 5)
        @(negedge clk);
        rst = 1'b0;
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL rmid_done got=%b exp=0", bus.done); end
        total++; if (nd !== 0) begin bad++; $display("FAIL rmid_early_done got=%0d exp=0", nd); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rmid_busy got=%b exp=0", bus.busy); end
        total++; if (bus.gate_addr !== 3'd0) begin bad++; $display("FAIL rmid_addr got=%0d exp=0", bus.gate_addr); end
        total++; if (bus.o_vector !== vec_t'(0)) begin bad++; $display("FAIL rmid_ovec got=%h exp=0", bus.o_vector); end
        total++; if (bus.mm_matrix !== mat_t'(0)) begin bad++; $display("FAIL rmid_mmat got=%h exp=0", bus.mm_matrix); end
        total++; if (bus.ovr_flag !== 1'b0) begin bad++; $display("FAIL rmid_ovr got=%b exp=0", bus.ovr_flag); end
        kick(4'd1, e0_half());
        run(8, -1, -1, d, n);
        exp_v = '0; exp_v[0] = 16'h2000;
        total++; if (d !== 4) begin bad++; $display("FAIL rmid_rerun_done got=%0d exp=4", d); end
        total++; if (ovs !== exp_v) begin bad++; $display("FAIL rmid_rerun_vec got=%h exp=%h", ovs, exp_v); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        for (int i = 0; i < MG; i++) mem[i] = '0;
        test_reset();
        test_single();
        test_two();
        test_order();
        test_zero();
        test_busy_start();
        test_overflow();
        test_max_gates();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/circuit_sequencer.md
CIRCUIT_SEQUENCER -- requirements
Module: circuit_sequencer

Interface
REQ-001 SHALL have parameter N, default 16, meaning word width of each real or imaginary component (Q15 sign-magnitude).
REQ-002 SHALL have parameter D, default 4, meaning state-vector dimension (2 qubits).
REQ-003 SHALL have parameter MAX_GATES, default 8, meaning gate memory depth; GW = $clog2(MAX_GATES), CW = $clog2(MAX_GATES+1).
REQ-004 SHALL have port clk, input, 1 bit, meaning the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit, meaning synchronous, active-high reset.
REQ-006 SHALL have port start, input, 1 bit, meaning a one-cycle request to run a circuit; sampled only in IDLE.
REQ-007 SHALL have port num_gates, input, CW bits, meaning gate count K, sampled with start.
REQ-008 SHALL have port init_vector, input, N x 2D array, meaning the initial state in re/im interleaved order, sampled with start.
REQ-009 SHALL have port gate_addr, output, GW bits, meaning the gate-memory read address.
REQ-010 SHALL have port gate_matrix, input, N x 2D² array, meaning the gate-memory read data, valid exactly one cycle after gate_addr is presented.
REQ-011 SHALL have port mm_matrix, output, N x 2D² array, meaning the matrix operand to the 2-qubit matmul.
REQ-012 SHALL have port mm_i_vector, output, N x 2D array, meaning the vector operand to the matmul.
REQ-013 SHALL have port mm_o_vector, input, N x 2D array, meaning the combinational matmul result.
REQ-014 SHALL have port mm_ovr, input, 1 bit, meaning the OR of all complex-multiply overflow flags.
REQ-015 SHALL have port busy, output, 1 bit, meaning high in every state except IDLE.
REQ-016 SHALL have port done, output, 1 bit, meaning a one-cycle completion pulse.
REQ-017 SHALL have port o_vector, output, N x 2D array, meaning the final state, held stable from done until the next accepted start.
REQ-018 SHALL have port ovr_flag, output, 1 bit, meaning sticky overflow for the current or last run.

Function
REQ-019 SHALL implement the FSM states IDLE, FETCH, CAPTURE, APPLY, DONE.
REQ-020 IDLE, start=1: SHALL load the state register from init_vector, set gate index g=0, clear ovr_flag, and latch Keff = min(num_gates, MAX_GATES); next state is FETCH if Keff>0, else DONE.
REQ-021 FETCH: SHALL drive gate_addr=g; next state is CAPTURE.
REQ-022 CAPTURE: SHALL latch gate_matrix into the matrix register; next state is APPLY.
REQ-023 APPLY: SHALL drive mm_matrix from the matrix register and mm_i_vector from the state register, latch mm_o_vector into the state register, and OR mm_ovr into ovr_flag; if g==Keff-1 the next state is DONE, else g increments and the next state is FETCH.
REQ-024 DONE: SHALL assert done=1 for exactly one cycle, drive o_vector from the state register, and return to IDLE.
REQ-025 Latency: with start sampled at cycle 0, done SHALL be high at cycle 3·Keff+1; Keff=0 SHALL give done at cycle 1 with o_vector=init_vector.
REQ-026 SHALL ignore start while busy, with no effect on g, the state register or ovr_flag.
REQ-027 Gate order SHALL be address 0 first, then ascending, giving result = G[K-1]·…·G[0]·init.
REQ-028 SHALL drive mm_matrix and mm_i_vector from registers at all times, so they hold their values outside APPLY.
REQ-029 SHALL hold gate_addr at its last value outside FETCH.
REQ-030 SHALL contain no arithmetic except the g increment and compare; all complex math belongs to the matmul.

Reset
REQ-031 On rst=1 at a clock edge, the FSM SHALL go to IDLE and the outputs SHALL be: busy=0, done=0, ovr_flag=0, gate_addr=0, g=0; o_vector, the state register, and the matrix register all zero.
REQ-032 Reset mid-run SHALL abort the run without a done pulse; a start in the first cycle after rst deasserts SHALL be accepted.
REQ-033 rst SHALL take priority over start in the same cycle.

Verification
REQ-034 K=1, G0=0.5·I (diagonal re=16'h4000), init[0].re=16'h4000, all else 0 -> done at cycle 4 with o_vector[0]=16'h2000, all else 0, and ovr_flag=0.
REQ-035 K=2, both gates 0.5·I, same init -> done at cycle 7 with o_vector[0]=16'h1000; gate_addr=0 then 1 during the two FETCH cycles.
REQ-036 K=0 -> done at cycle 1 and o_vector equals init_vector bit-exact.
REQ-037 start pulsed during APPLY of a K=3 run -> ignored, a single done at cycle 10, and busy high for cycles 1–9.
REQ-038 rst asserted in the CAPTURE of gate 1 -> no done pulse and all outputs at reset values next cycle; a start two cycles later runs to completion normally.
REQ-039 mm_ovr forced high for one APPLY cycle -> ovr_flag=1 through done, then cleared on the next accepted start; num_gates=MAX_GATES+3 -> exactly MAX_GATES gates applied.
